// File: rtl/obj_pkg.sv
// Shared types for the draw <-> storage object conversion paths.
// Field layouts here are also used by the draw-to-storage converter.
package obj_pkg;

    localparam int COORD_W = 10;
    localparam int PARAM_W = 36;
    localparam int VEL_W   = 16;
    localparam int RAW_W   = 12;
    localparam int NUM_COORDS = 8;

    // Bit offsets inside params_in and the draw descriptor
    localparam int PARAM_A_LSB   = 10;
    localparam int PARAM_B_LSB   = 0;
    localparam int PARAM_USED_W  = 20;
    localparam int DRAW_STAT_BIT = 82;
    localparam int DRAW_ID_LSB   = 80;
    localparam int DRAW_P1X_LSB  = 70;
    localparam int DRAW_P4Y_LSB  = 0;

    typedef enum logic [1:0] {
        OBJ_NONE   = 2'b00,
        OBJ_CIRCLE = 2'b01,
        OBJ_LINE   = 2'b10,
        OBJ_RECT   = 2'b11
    } obj_id_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_CLAMP,
        ST_OUT
    } conv_state_t;

    typedef struct packed {
        logic                 is_static;
        obj_id_t              id;
        logic [PARAM_W-1:0]   params;
        logic [COORD_W-1:0]   pos_x;
        logic [COORD_W-1:0]   pos_y;
        logic [VEL_W-1:0]     vel_x;
        logic [VEL_W-1:0]     vel_y;
    } storage_obj_t;

    typedef struct packed {
        logic                 is_static;
        obj_id_t              id;
        logic [COORD_W-1:0]   p1x;
        logic [COORD_W-1:0]   p1y;
        logic [COORD_W-1:0]   p2x;
        logic [COORD_W-1:0]   p2y;
        logic [COORD_W-1:0]   p3x;
        logic [COORD_W-1:0]   p3y;
        logic [COORD_W-1:0]   p4x;
        logic [COORD_W-1:0]   p4y;
    } draw_obj_t;

    // Unsigned screen value into the signed working width
    function automatic logic signed [RAW_W-1:0] widen(input logic [COORD_W-1:0] v);
        return {{(RAW_W-COORD_W){1'b0}}, v};
    endfunction

endpackage

// File: rtl/coord_clamp.sv
// Clamps one signed working coordinate onto the visible screen range [0, LIMIT-1].
module coord_clamp
    import obj_pkg::*;
#(
    parameter int LIMIT = 640
) (
    input  logic signed [RAW_W-1:0]   coord_i,
    output logic        [COORD_W-1:0] coord_o,
    output logic                      clipped_o
);

    localparam logic signed [RAW_W-1:0] MAX_VAL = RAW_W'(LIMIT - 1);

    always_comb begin
        coord_o   = coord_i[COORD_W-1:0];
        clipped_o = 1'b0;
        if (coord_i[RAW_W-1]) begin
            coord_o   = '0;
            clipped_o = 1'b1;
        end else if (coord_i > MAX_VAL) begin
            coord_o   = MAX_VAL[COORD_W-1:0];
            clipped_o = 1'b1;
        end
    end

endmodule

// File: rtl/storage_to_draw_conversion.sv
// Rebuilds the four-point draw descriptor from a stored physics object record.
// Pipeline: IDLE (accept) -> CALC (raw coords) -> CLAMP (screen clamp) -> OUT (hold).
module storage_to_draw_conversion
    import obj_pkg::*;
#(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 obj_valid_in,
    output logic                 obj_ready_out,
    input  logic                 is_static_in,
    input  logic [1:0]           id_bits_in,
    input  logic [PARAM_W-1:0]   params_in,
    input  logic [COORD_W-1:0]   pos_x_in,
    input  logic [COORD_W-1:0]   pos_y_in,
    input  logic [VEL_W-1:0]     vel_x_in,
    input  logic [VEL_W-1:0]     vel_y_in,
    output logic                 draw_valid_out,
    input  logic                 draw_ready_in,
    output logic [82:0]          draw_props_out,
    output logic                 clipped_out,
    output logic                 unknown_id_out
);

    conv_state_t state_q, state_d;
    storage_obj_t objIn, obj_q;

    logic [NUM_COORDS-1:0][RAW_W-1:0]   rawCoord_d, rawCoord_q;
    logic [NUM_COORDS-1:0]              clampEn_d, clampEn_q;
    logic [NUM_COORDS-1:0][COORD_W-1:0] clampVal, finalCoord;
    logic [NUM_COORDS-1:0]              clampHit;

    draw_obj_t drawNext, drawProps_q;
    logic      drawValid_q, clipped_q, unknown_q;
    logic      accept;
    logic signed [RAW_W-1:0] px, py, pa, pb;
    logic      unusedStorageBits;

    assign objIn = {is_static_in, id_bits_in, params_in, pos_x_in, pos_y_in, vel_x_in, vel_y_in};
    assign unusedStorageBits = ^{obj_q.vel_x, obj_q.vel_y, obj_q.params[PARAM_W-1:PARAM_USED_W]};

    assign obj_ready_out = (state_q == ST_IDLE) && !rst_in;
    assign accept        = obj_valid_in && obj_ready_out;

    assign px = widen(obj_q.pos_x);
    assign py = widen(obj_q.pos_y);
    assign pa = widen(obj_q.params[PARAM_A_LSB +: COORD_W]);
    assign pb = widen(obj_q.params[PARAM_B_LSB +: COORD_W]);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (obj_valid_in) state_d = ST_CALC;
            ST_CALC:  state_d = ST_CLAMP;
            ST_CLAMP: state_d = ST_OUT;
            ST_OUT:   if (draw_ready_in) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Index order p1x,p1y,p2x,p2y,p3x,p3y,p4x,p4y; clampEn marks clamped slots
    always_comb begin
        rawCoord_d = '0;
        clampEn_d  = '0;
        case (obj_q.id)
            OBJ_CIRCLE: begin
                rawCoord_d[0] = px - pb;
                rawCoord_d[1] = py - pb;
                rawCoord_d[2] = px + pb;
                rawCoord_d[3] = py + pb;
                rawCoord_d[4] = px;
                rawCoord_d[5] = py;
                rawCoord_d[6] = pb;
                clampEn_d     = 8'b0000_1111;
            end
            OBJ_LINE: begin
                rawCoord_d[0] = px;
                rawCoord_d[1] = py;
                rawCoord_d[2] = pa;
                rawCoord_d[3] = pb;
                clampEn_d     = 8'b0000_1100;
            end
            OBJ_RECT: begin
                rawCoord_d[0] = px;
                rawCoord_d[1] = py;
                rawCoord_d[2] = px + pa;
                rawCoord_d[3] = py;
                rawCoord_d[4] = px + pa;
                rawCoord_d[5] = py + pb;
                rawCoord_d[6] = px;
                rawCoord_d[7] = py + pb;
                clampEn_d     = 8'hFF;
            end
            default: ;
        endcase
    end

    for (genvar gi = 0; gi < NUM_COORDS; gi++) begin : g_clamp
        coord_clamp #(
            .LIMIT((gi % 2 == 0) ? SCREEN_W : SCREEN_H)
        ) u_clamp (
            .coord_i  (rawCoord_q[gi]),
            .coord_o  (clampVal[gi]),
            .clipped_o(clampHit[gi])
        );
        assign finalCoord[gi] = clampEn_q[gi] ? clampVal[gi] : rawCoord_q[gi][COORD_W-1:0];
    end

    always_comb begin
        drawNext.is_static = obj_q.is_static;
        drawNext.id        = obj_q.id;
        drawNext.p1x       = finalCoord[0];
        drawNext.p1y       = finalCoord[1];
        drawNext.p2x       = finalCoord[2];
        drawNext.p2y       = finalCoord[3];
        drawNext.p3x       = finalCoord[4];
        drawNext.p3y       = finalCoord[5];
        drawNext.p4x       = finalCoord[6];
        drawNext.p4y       = finalCoord[7];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            obj_q       <= '0;
            rawCoord_q  <= '0;
            clampEn_q   <= '0;
            drawProps_q <= '0;
            drawValid_q <= 1'b0;
            clipped_q   <= 1'b0;
            unknown_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                obj_q <= objIn;
            end
            if (state_q == ST_CALC) begin
                rawCoord_q <= rawCoord_d;
                clampEn_q  <= clampEn_d;
            end
            // Outputs only change here, so they stay frozen while OUT stalls
            if (state_q == ST_CLAMP) begin
                drawProps_q <= drawNext;
                clipped_q   <= |(clampEn_q & clampHit);
                unknown_q   <= (obj_q.id == OBJ_NONE);
                drawValid_q <= 1'b1;
            end
            if (state_q == ST_OUT && draw_ready_in) begin
                drawValid_q <= 1'b0;
            end
        end
    end

    assign draw_props_out = drawProps_q;
    assign draw_valid_out = drawValid_q;
    assign clipped_out    = clipped_q;
    assign unknown_id_out = unknown_q;

endmodule
